// File: rtl/fetch_bp.sv
// Fetch stage with a direct-mapped BTB and 2-bit saturating counters.
// Drives a combinational instruction memory and registers the F/D stage with prediction metadata.
module fetch_bp #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [31:0]     NOP_INSTR   = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            UpdEn,
  input  logic [XLEN-1:0] UpdPC,
  input  logic [XLEN-1:0] UpdTarget,
  input  logic            UpdTaken,
  output logic [XLEN-1:0] ImemAddr,
  input  logic [31:0]     ImemData,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] inc_PCD,
  output logic            PredTakenD,
  output logic [XLEN-1:0] PredTargetD
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0]        pcf_q, pcf_d;
  logic [31:0]            instr_q, instr_d;
  logic [XLEN-1:0]        pcd_q, pcd_d;
  logic [XLEN-1:0]        inc_q, inc_d;
  logic                   ptk_q, ptk_d;
  logic [XLEN-1:0]        ptgt_q, ptgt_d;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAGW-1:0]        btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];

  logic [IDX-1:0]         f_idx_s;
  logic                   f_hit_s;
  logic                   pred_taken_f_s;
  logic [XLEN-1:0]        pred_tgt_f_s;
  logic [XLEN-1:0]        pc_plus4_s;

  logic [IDX-1:0]         u_idx_s;
  logic [TAGW-1:0]        u_tag_s;
  logic                   u_hit_s;
  logic                   u_we_s;
  logic [1:0]             u_ctr_s;
  logic [XLEN-1:0]        u_tgt_s;
  logic                   unused_s;

  assign unused_s = ^{UpdPC[1:0]};

  // Lookup reads only the pre-update BTB contents, giving read-before-write on a shared index.
  assign f_idx_s        = pcf_q[IDX+1:2];
  assign f_hit_s        = btb_valid_q[f_idx_s] && (btb_tag_q[f_idx_s] == pcf_q[XLEN-1:IDX+2]);
  assign pred_taken_f_s = f_hit_s & btb_ctr_q[f_idx_s][1];
  assign pred_tgt_f_s   = f_hit_s ? btb_tgt_q[f_idx_s] : '0;
  assign pc_plus4_s     = pcf_q + XLEN'(32'd4);
  assign ImemAddr       = pcf_q;

  assign u_idx_s = UpdPC[IDX+1:2];
  assign u_tag_s = UpdPC[XLEN-1:IDX+2];
  assign u_hit_s = btb_valid_q[u_idx_s] && (btb_tag_q[u_idx_s] == u_tag_s);

  always_comb begin
    pcf_d = pcf_q;
    if (PCSrc) begin
      pcf_d = PCTarget;
    end else if (Stall) begin
      pcf_d = pcf_q;
    end else if (pred_taken_f_s) begin
      pcf_d = pred_tgt_f_s;
    end else begin
      pcf_d = pc_plus4_s;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    inc_d   = inc_q;
    ptk_d   = ptk_q;
    ptgt_d  = ptgt_q;
    if (Flush) begin
      instr_d = NOP_INSTR;
      pcd_d   = '0;
      inc_d   = '0;
      ptk_d   = 1'b0;
      ptgt_d  = '0;
    end else if (Stall) begin
      instr_d = instr_q;
    end else begin
      instr_d = ImemData;
      pcd_d   = pcf_q;
      inc_d   = pc_plus4_s;
      ptk_d   = pred_taken_f_s;
      ptgt_d  = pred_tgt_f_s;
    end
  end

  // Counter training on a tag hit; a taken miss allocates weakly-taken, a not-taken miss is dropped.
  always_comb begin
    u_we_s  = 1'b0;
    u_ctr_s = btb_ctr_q[u_idx_s];
    u_tgt_s = btb_tgt_q[u_idx_s];
    if (UpdEn && u_hit_s) begin
      u_we_s = 1'b1;
      if (UpdTaken) begin
        u_ctr_s = (btb_ctr_q[u_idx_s] == 2'b11) ? 2'b11 : btb_ctr_q[u_idx_s] + 2'b01;
        u_tgt_s = UpdTarget;
      end else begin
        u_ctr_s = (btb_ctr_q[u_idx_s] == 2'b00) ? 2'b00 : btb_ctr_q[u_idx_s] - 2'b01;
      end
    end else if (UpdEn && UpdTaken) begin
      u_we_s  = 1'b1;
      u_ctr_s = 2'b10;
      u_tgt_s = UpdTarget;
    end else begin
      u_we_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcf_q       <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pcd_q       <= '0;
      inc_q       <= '0;
      ptk_q       <= 1'b0;
      ptgt_q      <= '0;
      btb_valid_q <= '0;
    end else begin
      pcf_q   <= pcf_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      inc_q   <= inc_d;
      ptk_q   <= ptk_d;
      ptgt_q  <= ptgt_d;
      if (u_we_s) begin
        btb_valid_q[u_idx_s] <= 1'b1;
      end
    end
  end

  // Tag/target/counter storage needs no reset: entries are qualified by their valid bit.
  always_ff @(posedge clk) begin
    if (rst && u_we_s) begin
      btb_tag_q[u_idx_s] <= u_tag_s;
      btb_tgt_q[u_idx_s] <= u_tgt_s;
      btb_ctr_q[u_idx_s] <= u_ctr_s;
    end
  end

  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign inc_PCD     = inc_q;
  assign PredTakenD  = ptk_q;
  assign PredTargetD = ptgt_q;

endmodule

// File: tb/tb_fetch_bp.sv
// Bench for fetch_bp: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the PC, F/D register and BTB.
module tb_fetch_bp;

  logic        clk = 1'b0;
  logic        rst, Stall, Flush, PCSrc, UpdEn, UpdTaken;
  logic [31:0] PCTarget, UpdPC, UpdTarget;
  logic [31:0] ImemAddr, ImemData, InstrD, PCD, inc_PCD, PredTargetD;
  logic        PredTakenD;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic [31:0] m_pc, m_instr, m_pcd, m_inc, m_ptgt;
  bit          m_ptk;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  assign ImemData = imem_word(ImemAddr);

  fetch_bp dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .UpdEn(UpdEn), .UpdPC(UpdPC), .UpdTarget(UpdTarget),
    .UpdTaken(UpdTaken), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .InstrD(InstrD), .PCD(PCD), .inc_PCD(inc_PCD), .PredTakenD(PredTakenD),
    .PredTargetD(PredTargetD)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSrc = 1'b0; PCTarget = 32'd0;
    UpdEn = 1'b0; UpdPC = 32'd0; UpdTarget = 32'd0; UpdTaken = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    UpdEn = 1'b1; UpdPC = pc; UpdTarget = tgt; UpdTaken = tk;
  endtask

  task automatic redirect(input logic [31:0] t);
    PCSrc = 1'b1; PCTarget = t;
  endtask

  // Advances the model by one clock using the currently driven inputs.
  task automatic model_step();
    int          li, ui;
    bit          lhit, uhit, ptk;
    logic [31:0] ptgt, pc;
    pc   = m_pc;
    li   = int'((pc / 32'd4) % 32'd16);
    lhit = m_v[li] && (m_tag[li] == pc / 32'd64);
    ptk  = lhit && (m_ctr[li] >= 2);
    ptgt = lhit ? m_tgt[li] : 32'd0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      m_pc = 32'd0; m_instr = 32'h0000_0013; m_pcd = 32'd0; m_inc = 32'd0;
      m_ptk = 1'b0; m_ptgt = 32'd0;
    end else begin
      if (PCSrc)      m_pc = PCTarget;
      else if (Stall) m_pc = pc;
      else if (ptk)   m_pc = ptgt;
      else            m_pc = pc + 32'd4;
      if (Flush) begin
        m_instr = 32'h0000_0013; m_pcd = 32'd0; m_inc = 32'd0; m_ptk = 1'b0; m_ptgt = 32'd0;
      end else if (!Stall) begin
        m_instr = imem_word(pc); m_pcd = pc; m_inc = pc + 32'd4; m_ptk = ptk; m_ptgt = ptgt;
      end
      if (UpdEn) begin
        ui   = int'((UpdPC / 32'd4) % 32'd16);
        uhit = m_v[ui] && (m_tag[ui] == UpdPC / 32'd64);
        if (uhit && UpdTaken) begin
          m_ctr[ui] = (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
          m_tgt[ui] = UpdTarget;
        end else if (uhit) begin
          m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
        end else if (UpdTaken) begin
          m_v[ui] = 1'b1; m_tag[ui] = UpdPC / 32'd64; m_tgt[ui] = UpdTarget; m_ctr[ui] = 2;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_val("ImemAddr", ImemAddr, m_pc);
    check_val("InstrD", InstrD, m_instr);
    check_val("PCD", PCD, m_pcd);
    check_val("inc_PCD", inc_PCD, m_inc);
    check_val("PredTakenD", {31'd0, PredTakenD}, {31'd0, m_ptk});
    check_val("PredTargetD", PredTargetD, m_ptgt);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b0; tick();
    rst = 1'b0; tick();
    check_val("rst_pc", ImemAddr, 32'd0);
    check_val("rst_instr", InstrD, 32'h0000_0013);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_val("seq_pc", ImemAddr, 32'(4 * i));
      check_val("seq_instr", InstrD, imem_word(32'(4 * (i - 1))));
    end

    // Allocate 0x10 -> 0x40 and run from 0
    redirect(32'h0); upd(32'h10, 32'h40, 1'b1); tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_val("run_pc", ImemAddr, 32'(4 * i));
    end
    tick();
    check_val("pred_pc", ImemAddr, 32'h40);
    check_val("pred_pcd", PCD, 32'h10);
    check_val("pred_tk", {31'd0, PredTakenD}, 32'd1);
    check_val("pred_tgt", PredTargetD, 32'h40);

    // Train down to 0, then back up
    upd(32'h10, 32'h40, 1'b0); tick();
    upd(32'h10, 32'h40, 1'b0); tick();
    redirect(32'h10); tick();
    tick();
    check_val("ctr0_pc", ImemAddr, 32'h14);
    check_val("ctr0_tk", {31'd0, PredTakenD}, 32'd0);
    redirect(32'h10); upd(32'h10, 32'h40, 1'b1); tick();
    tick();
    check_val("ctr1_pc", ImemAddr, 32'h14);
    redirect(32'h10); upd(32'h10, 32'h40, 1'b1); tick();
    tick();
    check_val("ctr2_pc", ImemAddr, 32'h40);

    // Aliasing: 0x50 shares the index of 0x10
    redirect(32'h10); upd(32'h50, 32'h80, 1'b1); tick();
    tick();
    check_val("alias_miss", ImemAddr, 32'h14);
    redirect(32'h50); tick();
    tick();
    check_val("alias_hit", ImemAddr, 32'h80);

    // Stall, redirect under stall, flush under stall
    for (int i = 0; i < 3; i++) begin
      Stall = 1'b1; tick();
      check_val("stall_pc", ImemAddr, 32'h80);
    end
    Stall = 1'b1; redirect(32'h200); tick();
    check_val("stall_redir", ImemAddr, 32'h200);
    Stall = 1'b1; Flush = 1'b1; tick();
    check_val("flush_instr", InstrD, 32'h0000_0013);
    check_val("flush_tk", {31'd0, PredTakenD}, 32'd0);
    check_val("flush_pc", ImemAddr, 32'h200);

    // Same-cycle lookup and allocate on 0x10
    redirect(32'h10); tick();
    upd(32'h10, 32'h40, 1'b1); tick();
    check_val("rbw_pc", ImemAddr, 32'h14);
    redirect(32'h10); tick();
    tick();
    check_val("rbw_refetch", ImemAddr, 32'h40);

    // PC wrap
    redirect(32'hFFFF_FFFC); tick();
    tick();
    check_val("wrap_pc", ImemAddr, 32'h0);

    // Random traffic in a small address window so BTB hits and aliasing occur
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(0, 63) != 0);
      Stall    = ($urandom_range(0, 6) == 0);
      Flush    = ($urandom_range(0, 9) == 0);
      PCSrc    = ($urandom_range(0, 9) == 0);
      PCTarget = 32'($urandom_range(0, 63)) << 2;
      UpdEn    = ($urandom_range(0, 9) < 4);
      UpdPC    = 32'($urandom_range(0, 127)) << 2;
      UpdTarget = 32'($urandom_range(0, 63)) << 2;
      UpdTaken = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_bp.md
Name: fetch_bp

Overview:
Parametrised successor to the pipeline fetch stage of the team's 5-stage RISC-V core. It holds the fetch PC and drives an external combinational instruction memory. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps are predicted in F. It registers the F/D pipeline stage, including the prediction metadata, for the E-stage misprediction check.

Parameters:
XLEN, 32, datapath/PC width.
BTB_ENTRIES, 16, BTB entry count; power of 2, >=2; IDX = log2(BTB_ENTRIES).
RESET_PC, 0, PC value loaded by reset.
NOP_INSTR, 32'h0000_0013, instruction inserted on flush/reset (addi x0,x0,0).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-low reset.
Stall  in  1  hold PCF and F/D register.
Flush  in  1  load bubble into F/D register.
PCSrc  in  1  redirect from E (mispredict correction or resolved jump).
PCTarget  in  XLEN  redirect address.
UpdEn  in  1  BTB update strobe from E (resolved branch/jump).
UpdPC  in  XLEN  PC of the resolved instruction.
UpdTarget  in  XLEN  resolved target.
UpdTaken  in  1  resolved direction.
ImemAddr  out  XLEN  = PCF (combinational).
ImemData  in  32  instruction at ImemAddr (combinational read).
InstrD  out  32  decoded-stage instruction.
PCD  out  XLEN  PC of InstrD.
inc_PCD  out  XLEN  PCD+4.
PredTakenD  out  1  InstrD was predicted taken.
PredTargetD  out  XLEN  predicted target (valid when PredTakenD=1).

Behaviour:
- Reset (rst=0 at an edge): PCF=RESET_PC; InstrD=NOP_INSTR; PCD=0; inc_PCD=0; PredTakenD=0; PredTargetD=0. All BTB valid bits are cleared; targets and counters are don't-care. Reset overrides every other input.
- BTB entry: valid, tag = PC[XLEN-1:IDX+2], target, ctr[1:0]. Index = PC[IDX+1:2]. PC[1:0] is ignored.
- Lookup (combinational on PCF): hit = valid & tag match. PredTakenF = hit & ctr[1]. PredTargetF = target if hit, else 0.
- PCNext priority:
  1. PCSrc: PCNext = PCTarget.
  2. Stall: PCF holds.
  3. PredTakenF: PCNext = PredTargetF.
  4. Otherwise: PCNext = PCF+4, wrapping modulo 2^XLEN.
  PCSrc overrides Stall: a redirect is always taken.
- F/D register priority:
  1. Flush: InstrD=NOP_INSTR, PredTakenD=0, PredTargetD=0, PCD/inc_PCD=0. Flush beats Stall.
  2. Stall: hold.
  3. Otherwise: capture ImemData, PCF, PCF+4, PredTakenF, PredTargetF.
- Latency: an instruction at PCF appears on InstrD one cycle later. A trained BTB hit gives zero-bubble redirect (target fetched the next cycle).
- BTB update on an edge with UpdEn=1, indexed by UpdPC:
  - Tag hit, UpdTaken=1: ctr = min(ctr+1, 3); target = UpdTarget.
  - Tag hit, UpdTaken=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), UpdTaken=1: allocate/replace with valid=1, new tag, target = UpdTarget, ctr = 2'b10.
  - Miss, UpdTaken=0: no change.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents (read-before-write). The new state is visible next cycle.
- UpdEn is independent of Stall/Flush and is applied even while stalled.
- No combinational path from ImemData to ImemAddr.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release, no updates, Imem returns PC-derived words -> PCF=0,4,8,12 on consecutive cycles; first InstrD = word@0 one cycle after release; PredTakenD=0 throughout.
- Allocate and predict: UpdEn with UpdPC=0x10, UpdTarget=0x40, UpdTaken=1, then run from 0 -> fetch sequence 0x0,0x4,0x8,0xC,0x10,0x40; D-stage entry for 0x10 has PredTakenD=1, PredTargetD=0x40.
- Counter training: after allocation (ctr=2), two not-taken updates on 0x10 -> ctr=0; next fetch of 0x10 is followed by 0x14 and PredTakenD=0. One taken update -> ctr=1, still not taken; a second -> taken.
- Aliasing: with BTB_ENTRIES=16, allocate 0x10 then 0x50 (same index) -> 0x10 now misses and fetches sequentially; 0x50 predicts.
- Stall/redirect/flush: Stall=1 for 3 cycles -> PCF and all D outputs constant. Stall=1 with PCSrc=1, PCTarget=0x200 -> PCF=0x200 next cycle. Flush=1 with Stall=1 -> InstrD=0x00000013, PredTakenD=0.
- Same-cycle hazard: PCF=0x10 with UpdEn allocating 0x10 in the same cycle -> that fetch predicts not-taken (next 0x14). A refetch of 0x10 predicts taken.
